// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the two-master sram-like request arbiter.
// Source IDs, sram-like field widths and the default outstanding depth.
package sram_req_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam int SIZE_W  = 2;
  localparam int STRB_W  = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  localparam int OT_DEPTH_DEF = 4;
  localparam int OT_AW_DEF    = 2;

endpackage

// File: rtl/sram_tag_fifo.sv
// 1-bit-wide in-order tag FIFO holding the source ID of every accepted,
// not-yet-answered request. Pointers wrap naturally (DEPTH is a power of two).
module sram_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        din,
  output logic        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign count     = r_cnt;
  assign dout      = r_mem[r_rptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Tag storage: write the pushed source ID at the write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (w_do_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointer and occupancy update; push+pop leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-master sram-like arbiter: IF and EXE share one downstream port.
// Requests pass through combinationally; responses are steered back using
// an in-order tag FIFO. Optional macro ARB_RR_EN switches the
// both-requesting tie-break from fixed data-over-inst to round-robin.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OT_DEPTH = OT_DEPTH_DEF,
  parameter int OT_AW    = OT_AW_DEF
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [SIZE_W-1:0] inst_sram_size,
  input  logic [STRB_W-1:0] inst_sram_wstrb,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,

  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [SIZE_W-1:0] data_sram_size,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [OT_AW:0]    ot_cnt,
  output logic              resp_err
);

  logic r_lock;
  logic r_lock_src;
  logic r_resp_err;

  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_lock_req;
  logic w_gnt_req;
  logic w_gnt_src;
  logic w_push;
  logic w_pop;
  logic w_inst_dok;
  logic w_data_dok;

`ifdef ARB_RR_EN
  logic r_rr_last;
`endif

  // A lock only holds while the locked master keeps its request up, so an
  // exception-driven cancel on EXE falls straight through to re-arbitration.
  assign w_lock_req = (r_lock_src == SRC_DATA) ? data_sram_req : inst_sram_req;

  // Grant select: full blocks everything, then lock, then tie-break
  always_comb begin
    w_gnt_req = 1'b0;
    w_gnt_src = SRC_INST;
    if (!w_full) begin
      if (r_lock && w_lock_req) begin
        w_gnt_req = 1'b1;
        w_gnt_src = r_lock_src;
      end else if (data_sram_req && inst_sram_req) begin
        w_gnt_req = 1'b1;
`ifdef ARB_RR_EN
        w_gnt_src = ~r_rr_last;
`else
        w_gnt_src = SRC_DATA;
`endif
      end else if (data_sram_req) begin
        w_gnt_req = 1'b1;
        w_gnt_src = SRC_DATA;
      end else if (inst_sram_req) begin
        w_gnt_req = 1'b1;
        w_gnt_src = SRC_INST;
      end
    end
  end

  // Forward the granted master's request fields downstream
  always_comb begin
    mem_req = w_gnt_req;
    if (w_gnt_src == SRC_DATA) begin
      mem_wr    = data_sram_wr;
      mem_size  = data_sram_size;
      mem_wstrb = data_sram_wstrb;
      mem_addr  = data_sram_addr;
      mem_wdata = data_sram_wdata;
    end else begin
      mem_wr    = inst_sram_wr;
      mem_size  = inst_sram_size;
      mem_wstrb = inst_sram_wstrb;
      mem_addr  = inst_sram_addr;
      mem_wdata = inst_sram_wdata;
    end
  end

  assign inst_sram_addr_ok = w_gnt_req && mem_addr_ok && (w_gnt_src == SRC_INST);
  assign data_sram_addr_ok = w_gnt_req && mem_addr_ok && (w_gnt_src == SRC_DATA);

  assign w_push = w_gnt_req && mem_addr_ok;
  assign w_pop  = mem_data_ok && !w_empty;

  assign w_inst_dok = w_pop && (w_head == SRC_INST);
  assign w_data_dok = w_pop && (w_head == SRC_DATA);

  assign inst_sram_data_ok = w_inst_dok;
  assign data_sram_data_ok = w_data_dok;
  assign inst_sram_rdata   = w_inst_dok ? mem_rdata : '0;
  assign data_sram_rdata   = w_data_dok ? mem_rdata : '0;
  assign resp_err          = r_resp_err;

  sram_tag_fifo #(
    .DEPTH (OT_DEPTH),
    .AW    (OT_AW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_gnt_src),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (ot_cnt)
  );

  // Lock on a stalled request; any accept or an idle cycle releases it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock     <= 1'b0;
      r_lock_src <= SRC_INST;
    end else if (w_gnt_req && !mem_addr_ok) begin
      r_lock     <= 1'b1;
      r_lock_src <= w_gnt_src;
    end else begin
      r_lock     <= 1'b0;
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resp_err <= 1'b0;
    end else if (mem_data_ok && w_empty) begin
      r_resp_err <= 1'b1;
    end
  end

`ifdef ARB_RR_EN
  // Remember the last accepted source for the round-robin tie-break
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_last <= SRC_INST;
    end else if (w_push) begin
      r_rr_last <= w_gnt_src;
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter. Expected response owners are
// queued when a request is accepted and popped when a response is driven.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  localparam int OT_DEPTH = 4;
  localparam int OT_AW    = 2;
  localparam logic [31:0] IA = 32'h0000_A000;
  localparam logic [31:0] DA = 32'h0000_B000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [OT_AW:0] ot_cnt;
  logic        resp_err;

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  sram_req_arbiter #(.OT_DEPTH(OT_DEPTH), .OT_AW(OT_AW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_wstrb         (mem_wstrb),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .mem_rdata         (mem_rdata),
    .ot_cnt            (ot_cnt),
    .resp_err          (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'h0;
    inst_sram_addr = IA; inst_sram_wdata = 32'h0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'h0;
    data_sram_addr = DA; data_sram_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  // Expect the named source to be granted and accepted this cycle
  task automatic accept(input string tag, input bit src, input logic [31:0] addr);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_iaok"}, {31'd0, inst_sram_addr_ok}, {31'd0, src == SRC_INST});
    chk({tag, "_daok"}, {31'd0, data_sram_addr_ok}, {31'd0, src == SRC_DATA});
    exp_q.push_back(src);
  endtask

  // Drive one downstream response and check it lands on the expected owner
  task automatic resp(input string tag, input logic [31:0] rd);
    bit src;
    mem_data_ok = 1; mem_rdata = rd;
    settle();
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
    end else begin
      src = exp_q.pop_front();
      chk({tag, "_idok"}, {31'd0, inst_sram_data_ok}, {31'd0, src == SRC_INST});
      chk({tag, "_ddok"}, {31'd0, data_sram_data_ok}, {31'd0, src == SRC_DATA});
      chk({tag, "_irdata"}, inst_sram_rdata, (src == SRC_INST) ? rd : 32'h0);
      chk({tag, "_drdata"}, data_sram_rdata, (src == SRC_DATA) ? rd : 32'h0);
    end
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      resp(tag, $urandom);
      cyc();
      mem_data_ok = 0;
    end
    settle();
    chk({tag, "_otcnt0"}, {29'd0, ot_cnt}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    resetn = 0;
    #2;
    chk("rst_otcnt", {29'd0, ot_cnt}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_aok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
    chk("rst_dok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    cyc();
    resetn = 1;
    cyc();

    // Priority: data wins a simultaneous request, inst follows
    inst_sram_req = 1; inst_sram_addr = 32'h100;
    data_sram_req = 1; data_sram_addr = 32'h200; data_sram_wr = 1;
    data_sram_wstrb = 4'hF; data_sram_wdata = 32'hCAFE_0001; data_sram_size = 2'd2;
    mem_addr_ok = 1;
    settle();
    accept("prio_d", SRC_DATA, 32'h200);
    chk("prio_wr", {31'd0, mem_wr}, 32'd1);
    chk("prio_wdata", mem_wdata, 32'hCAFE_0001);
    chk("prio_wstrb", {28'd0, mem_wstrb}, 32'hF);
    cyc();
    data_sram_req = 0; data_sram_wr = 0;
    settle();
    accept("prio_i", SRC_INST, 32'h100);
    chk("prio_iwr", {31'd0, mem_wr}, 32'd0);
    cyc();
    inst_sram_req = 0; mem_addr_ok = 0;
    settle();
    chk("prio_otcnt", {29'd0, ot_cnt}, 32'd2);
    resp("prio_r1", 32'h1111_1111);
    cyc();
    resp("prio_r2", 32'h2222_2222);
    cyc();
    mem_data_ok = 0;
    settle();
    chk("prio_otcnt0", {29'd0, ot_cnt}, 32'd0);

    // Lock on data: stays on data address for 3 stalled cycles
    data_sram_req = 1; data_sram_addr = 32'h300;
    inst_sram_req = 1; inst_sram_addr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lockd_addr", mem_addr, 32'h300);
      chk("lockd_iaok", {31'd0, inst_sram_addr_ok}, 32'd0);
      chk("lockd_daok", {31'd0, data_sram_addr_ok}, 32'd0);
      cyc();
    end
    mem_addr_ok = 1;
    settle();
    accept("lockd_acc", SRC_DATA, 32'h300);
    cyc();
    data_sram_req = 0;
    settle();
    accept("lockd_inst", SRC_INST, 32'h400);
    cyc();
    // Lock on inst: a later data request must not steal the port
    mem_addr_ok = 0; inst_sram_addr = 32'h500;
    settle();
    chk("locki_addr0", mem_addr, 32'h500);
    cyc();
    data_sram_req = 1; data_sram_addr = 32'h600;
    settle();
    chk("locki_addr1", mem_addr, 32'h500);
    chk("locki_daok", {31'd0, data_sram_addr_ok}, 32'd0);
    cyc();
    mem_addr_ok = 1;
    settle();
    accept("locki_acc", SRC_INST, 32'h500);
    cyc();
    inst_sram_req = 0;
    settle();
    accept("locki_data", SRC_DATA, 32'h600);
    cyc();
    idle();
    drain("lock_drain", 4);

    // Cancel: locked data drops req, inst taken in the same cycle
    data_sram_req = 1; data_sram_addr = 32'h700;
    inst_sram_req = 1; inst_sram_addr = 32'h800;
    settle();
    chk("cand_addr", mem_addr, 32'h700);
    cyc();
    data_sram_req = 0; mem_addr_ok = 1;
    settle();
    accept("cand_inst", SRC_INST, 32'h800);
    cyc();
    idle();
    settle();
    chk("cand_otcnt", {29'd0, ot_cnt}, 32'd1);
    // Cancel: locked inst drops req, data taken in the same cycle
    inst_sram_req = 1; inst_sram_addr = 32'h900;
    settle();
    chk("cani_addr", mem_addr, 32'h900);
    cyc();
    inst_sram_req = 0;
    data_sram_req = 1; data_sram_addr = 32'hA00; mem_addr_ok = 1;
    settle();
    accept("cani_data", SRC_DATA, 32'hA00);
    cyc();
    idle();
    drain("cancel_drain", 2);

    // Full: four inst reads fill the FIFO; pop does not unblock same cycle
    inst_sram_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < OT_DEPTH; i++) begin
      inst_sram_addr = 32'h1000 + 32'(i * 4);
      settle();
      accept("full_fill", SRC_INST, 32'h1000 + 32'(i * 4));
      cyc();
    end
    inst_sram_addr = 32'h1010;
    settle();
    chk("full_otcnt4", {29'd0, ot_cnt}, 32'd4);
    chk("full_memreq", {31'd0, mem_req}, 32'd0);
    resp("full_pop", 32'h3333_3333);
    chk("full_pop_memreq", {31'd0, mem_req}, 32'd0);
    chk("full_pop_iaok", {31'd0, inst_sram_addr_ok}, 32'd0);
    cyc();
    mem_data_ok = 0;
    settle();
    chk("full_otcnt3", {29'd0, ot_cnt}, 32'd3);
    accept("full_next", SRC_INST, 32'h1010);
    cyc();
    idle();
    drain("full_drain", 4);

    // Spurious response with nothing outstanding
    mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("spur_dok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    chk("spur_irdata", inst_sram_rdata, 32'h0);
    chk("spur_drdata", data_sram_rdata, 32'h0);
    cyc();
    mem_data_ok = 0;
    settle();
    chk("spur_err", {31'd0, resp_err}, 32'd1);
    cyc();
    cyc();
    chk("spur_err_sticky", {31'd0, resp_err}, 32'd1);
    chk("spur_otcnt", {29'd0, ot_cnt}, 32'd0);
    // Async reset in the middle of a burst
    inst_sram_req = 1; inst_sram_addr = 32'h2000; mem_addr_ok = 1;
    settle();
    accept("burst0", SRC_INST, 32'h2000);
    cyc();
    inst_sram_addr = 32'h2004;
    settle();
    accept("burst1", SRC_INST, 32'h2004);
    cyc();
    idle();
    settle();
    chk("burst_otcnt", {29'd0, ot_cnt}, 32'd2);
    resetn = 0;
    #1;
    chk("arst_otcnt", {29'd0, ot_cnt}, 32'd0);
    chk("arst_err", {31'd0, resp_err}, 32'd0);
    exp_q.delete();
    cyc();
    resetn = 1;
    inst_sram_req = 1; inst_sram_addr = 32'h2100; mem_addr_ok = 1;
    settle();
    accept("post_rst", SRC_INST, 32'h2100);
    cyc();
    idle();
    drain("post_drain", 1);

    // Continuous contention with always-ready downstream
    inst_sram_req = 1; data_sram_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
`ifdef ARB_RR_EN
      if (i % 2 == 0) accept("rr_grant", SRC_DATA, DA);
      else            accept("rr_grant", SRC_INST, IA);
`else
      accept("fix_grant", SRC_DATA, DA);
`endif
      cyc();
    end
    idle();
    drain("contend_drain", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
